// File: rtl/key_sequencer_pkg.sv
// Shared definitions for the key sequencer slice.
// Holds the key-press bit layout, brick position/direction widths, the
// column extraction macro and the sequencer state encodings. The macros are
// the header-style names the game controller uses; the package re-exports
// them as typed constants for the RTL and the bench.
`ifndef KEY_SEQ_DEFINES
`define KEY_SEQ_DEFINES
`define KEY_PRESS_LEN 5
`define KEY_UP        0
`define KEY_DOWN      1
`define KEY_LEFT      2
`define KEY_RIGHT     3
`define KEY_SPACE     4
`define POS_LEN       8
`define DIR_LEN       2
// Brick anchor position is {y, x}; the column lives in the low half.
`define GETX(p)       ((p)[3:0])
`define SEQ_IDLE      3'd0
`define SEQ_ROTATE    3'd1
`define SEQ_SHIFT     3'd2
`define SEQ_DROP      3'd3
`define SEQ_DONE      3'd4
`endif

package key_sequencer_pkg;
  localparam int KEY_PRESS_LEN = `KEY_PRESS_LEN;
  localparam int KEY_UP        = `KEY_UP;
  localparam int KEY_DOWN      = `KEY_DOWN;
  localparam int KEY_LEFT      = `KEY_LEFT;
  localparam int KEY_RIGHT     = `KEY_RIGHT;
  localparam int KEY_SPACE     = `KEY_SPACE;
  localparam int POS_LEN       = `POS_LEN;
  localparam int DIR_LEN       = `DIR_LEN;
  // Width of the column field inside a position word.
  localparam int X_POS_W       = POS_LEN / 2;

  typedef enum logic [2:0] {
    S_IDLE   = `SEQ_IDLE,
    S_ROTATE = `SEQ_ROTATE,
    S_SHIFT  = `SEQ_SHIFT,
    S_DROP   = `SEQ_DROP,
    S_DONE   = `SEQ_DONE
  } seq_state_e;
endpackage

// File: rtl/key_sequencer_seq_progress_check.sv
// seq_progress_check: post-pulse settle timer and progress watchdog.
// On pulse it records the observed value and loads the gap counter with GAP.
// The counter runs down to 0; on the step into 0 the observed value is
// compared with the recorded one. No change bumps the fail counter, a change
// clears it. clear resets the fail counter (phase change / new request).
// Ports:
//   main_clk, rst_1plus : clock, async active-high reset
//   clear               : zero the fail counter
//   pulse               : a key pulse is being issued this cycle
//   obs [W-1:0]         : value being steered (direction or column)
//   ready               : gap counter is 0, a new decision may be taken
//   fail_limit          : MAX_FAIL consecutive no-progress pulses seen
module seq_progress_check #(
  parameter int GAP      = 3,
  parameter int MAX_FAIL = 4,
  parameter int W        = 4
) (
  input  logic         main_clk,
  input  logic         rst_1plus,
  input  logic         clear,
  input  logic         pulse,
  input  logic [W-1:0] obs,
  output logic         ready,
  output logic         fail_limit
);
  localparam int FW = $clog2(MAX_FAIL + 1);

  logic [3:0]    gap_cnt;
  logic [FW-1:0] fail_cnt;
  logic [W-1:0]  rec;

  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      gap_cnt  <= '0;
      fail_cnt <= '0;
      rec      <= '0;
    end else begin
      if (pulse) begin
        gap_cnt <= 4'(GAP);
        rec     <= obs;
      end else if (gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
      // Clear and the end-of-gap compare never coincide: the FSM only
      // clears when ready, i.e. after the compare has already happened.
      if (clear) begin
        fail_cnt <= '0;
      end else if (!pulse && gap_cnt == 4'd1) begin
        if (obs == rec) fail_cnt <= fail_cnt + FW'(1);
        else            fail_cnt <= '0;
      end
    end
  end

  assign ready      = (gap_cnt == 4'd0);
  assign fail_limit = (fail_cnt >= FW'(MAX_FAIL));
endmodule

// File: rtl/key_sequencer.sv
// key_sequencer: autoplay key-stimulus generator.
// After start it rotates the brick (UP) to target_dir, shifts it
// (LEFT/RIGHT) to target_x, then drops it (SPACE). Each pulse is followed by
// a GAP-cycle settle before the brick feedback is trusted; a phase that makes
// no progress for MAX_FAIL pulses is abandoned and blocked is flagged.
// Ports:
//   main_clk, rst_1plus      : clock, async active-high reset
//   start                    : one-cycle request, latches targets in IDLE
//   target_x, target_dir     : desired column / rotation
//   cur_pos, cur_dir         : brick feedback from the game controller
//   game_idle                : game FSM in WAIT, pulses allowed
//   key_press_1plus          : registered one-hot one-cycle key pulses
//   busy, done, blocked      : request status (done is a one-cycle pulse,
//                              blocked is sticky until the next start)
module key_sequencer
  import key_sequencer_pkg::*;
#(
  parameter int GAP      = 3,
  parameter int MAX_FAIL = 4,
  parameter int X_LEN    = 4
) (
  input  logic                     main_clk,
  input  logic                     rst_1plus,
  input  logic                     start,
  input  logic [X_LEN-1:0]         target_x,
  input  logic [DIR_LEN-1:0]       target_dir,
  input  logic [POS_LEN-1:0]       cur_pos,
  input  logic [DIR_LEN-1:0]       cur_dir,
  input  logic                     game_idle,
  output logic [KEY_PRESS_LEN-1:0] key_press_1plus,
  output logic                     busy,
  output logic                     done,
  output logic                     blocked
);
  localparam int OBS_W = (X_LEN > DIR_LEN) ? X_LEN : DIR_LEN;

  seq_state_e               state, state_nxt;
  logic [X_LEN-1:0]         tx_q;
  logic [DIR_LEN-1:0]       tdir_q;
  logic [KEY_PRESS_LEN-1:0] key_nxt;
  logic                     busy_nxt, done_nxt, blocked_nxt, latch;
  logic                     pc_pulse, pc_clear, pc_ready, pc_limit;
  logic [X_LEN-1:0]         cur_x;
  logic [OBS_W-1:0]         obs;
  logic                     unused_pos_y;

  assign cur_x        = X_LEN'(cur_pos[X_POS_W-1:0]);
  assign unused_pos_y = ^cur_pos[POS_LEN-1:X_POS_W];

  // The checker watches whichever quantity the current phase steers. State
  // cannot change during a gap, so the mux is stable across the compare.
  assign obs = (state == S_SHIFT) ? OBS_W'(cur_x) : OBS_W'(cur_dir);

  seq_progress_check #(.GAP(GAP), .MAX_FAIL(MAX_FAIL), .W(OBS_W)) u_chk (
    .main_clk  (main_clk),
    .rst_1plus (rst_1plus),
    .clear     (pc_clear),
    .pulse     (pc_pulse),
    .obs       (obs),
    .ready     (pc_ready),
    .fail_limit(pc_limit)
  );

  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      state           <= S_IDLE;
      tx_q            <= '0;
      tdir_q          <= '0;
      key_press_1plus <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      blocked         <= 1'b0;
    end else begin
      state           <= state_nxt;
      key_press_1plus <= key_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
      blocked         <= blocked_nxt;
      if (latch) begin
        tx_q   <= target_x;
        tdir_q <= target_dir;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    key_nxt     = '0;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    blocked_nxt = blocked;
    latch       = 1'b0;
    pc_pulse    = 1'b0;
    pc_clear    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          latch       = 1'b1;
          busy_nxt    = 1'b1;
          blocked_nxt = 1'b0;
          pc_clear    = 1'b1;
          state_nxt   = S_ROTATE;
        end
      end
      S_ROTATE: begin
        if (pc_ready) begin
          // Giving up does not need game_idle: no pulse is issued.
          if (pc_limit) begin
            blocked_nxt = 1'b1;
            pc_clear    = 1'b1;
            state_nxt   = S_SHIFT;
          end else if (game_idle) begin
            if (cur_dir == tdir_q) begin
              pc_clear  = 1'b1;
              state_nxt = S_SHIFT;
            end else begin
              key_nxt[KEY_UP] = 1'b1;
              pc_pulse        = 1'b1;
            end
          end
        end
      end
      S_SHIFT: begin
        if (pc_ready) begin
          if (pc_limit) begin
            blocked_nxt = 1'b1;
            pc_clear    = 1'b1;
            state_nxt   = S_DROP;
          end else if (game_idle) begin
            if (cur_x == tx_q) begin
              pc_clear  = 1'b1;
              state_nxt = S_DROP;
            end else if (cur_x < tx_q) begin
              key_nxt[KEY_RIGHT] = 1'b1;
              pc_pulse           = 1'b1;
            end else begin
              key_nxt[KEY_LEFT] = 1'b1;
              pc_pulse          = 1'b1;
            end
          end
        end
      end
      S_DROP: begin
        if (pc_ready && game_idle) begin
          key_nxt[KEY_SPACE] = 1'b1;
          state_nxt          = S_DONE;
        end
      end
      S_DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_key_sequencer.sv
// Bench for key_sequencer: a small game model answers key pulses, a
// scoreboard queue holds the key order each sequence must produce.
module tb_key_sequencer;
  import key_sequencer_pkg::*;

  localparam int GAP = 3;
  localparam logic [4:0] K_UP    = 5'b00001;
  localparam logic [4:0] K_LEFT  = 5'b00100;
  localparam logic [4:0] K_RIGHT = 5'b01000;
  localparam logic [4:0] K_SPACE = 5'b10000;

  logic       main_clk = 1'b0;
  logic       rst_1plus, start, game_idle;
  logic [3:0] target_x;
  logic [1:0] target_dir;
  logic [7:0] cur_pos;
  logic [1:0] cur_dir;
  logic [4:0] key_press_1plus;
  logic       busy, done, blocked;

  always #5 main_clk = ~main_clk;

  key_sequencer #(.GAP(GAP), .MAX_FAIL(4), .X_LEN(4)) dut (
    .main_clk       (main_clk),
    .rst_1plus      (rst_1plus),
    .start          (start),
    .target_x       (target_x),
    .target_dir     (target_dir),
    .cur_pos        (cur_pos),
    .cur_dir        (cur_dir),
    .game_idle      (game_idle),
    .key_press_1plus(key_press_1plus),
    .busy           (busy),
    .done           (done),
    .blocked        (blocked)
  );

  // game model state
  logic [3:0] mx, m_wall;
  logic [1:0] mdir;
  logic       m_frz;
  logic [4:0] pend_k;
  int         pend_cnt;

  assign cur_pos = {4'h0, mx};
  assign cur_dir = mdir;

  typedef struct {
    logic [3:0] x0; logic [1:0] d0; logic [3:0] tx; logic [1:0] td;
    logic [3:0] wall; logic frz; int nup; int nl; int nr; logic blk;
  } vec_t;
  vec_t vecs[7];

  logic [4:0] exp_q[$];
  int errors = 0, checks = 0, cyc = 0, prev_cyc = 0;
  logic [4:0] prev_k;
  logic       idle_lost;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge, score any pulse, advance the model.
  task automatic tick();
    logic gi;
    logic [4:0] k, e;
    gi = game_idle;
    @(negedge main_clk);
    cyc++;
    k = key_press_1plus;
    if (!gi) idle_lost = 1'b1;
    if (k != 5'd0) begin
      chk("pulse_onehot_idle", {31'd0, $onehot(k) && gi}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(k), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("key_order", 32'(k), 32'(e));
      end
      if (k == prev_k && k != K_SPACE && !idle_lost)
        chk("pulse_spacing", 32'(cyc - prev_cyc), 32'(GAP + 1));
      prev_k = k; prev_cyc = cyc; idle_lost = 1'b0;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        if (pend_k == K_UP && !m_frz)           mdir = mdir + 2'd1;
        if (pend_k == K_RIGHT && mx < m_wall)   mx = mx + 4'd1;
        if (pend_k == K_LEFT && mx > 4'd0)      mx = mx - 4'd1;
      end
    end
    if (k != 5'd0) begin pend_k = k; pend_cnt = 1; end
  endtask

  task automatic load(input logic [3:0] x, input logic [1:0] d, input logic [3:0] wall, input logic frz);
    mx = x; mdir = d; m_wall = wall; m_frz = frz; pend_cnt = 0;
    exp_q.delete(); prev_k = 5'd0; idle_lost = 1'b0; game_idle = 1'b1;
    tick(); tick();
  endtask

  task automatic push_exp(input int nup, input int nl, input int nr);
    for (int i = 0; i < nup; i++) exp_q.push_back(K_UP);
    for (int i = 0; i < nl; i++)  exp_q.push_back(K_LEFT);
    for (int i = 0; i < nr; i++)  exp_q.push_back(K_RIGHT);
    exp_q.push_back(K_SPACE);
  endtask

  task automatic start_seq(input logic [3:0] tx, input logic [1:0] td);
    target_x = tx; target_dir = td; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_pulse(input logic [4:0] want, input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      if (key_press_1plus == want) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int np;
    vecs[0] = '{4'd6, 2'd0, 4'd6, 2'd0, 4'd15, 1'b0, 0, 0, 0, 1'b0};
    vecs[1] = '{4'd6, 2'd0, 4'd6, 2'd3, 4'd15, 1'b0, 3, 0, 0, 1'b0};
    vecs[2] = '{4'd6, 2'd0, 4'd2, 2'd0, 4'd15, 1'b0, 0, 4, 0, 1'b0};
    vecs[3] = '{4'd6, 2'd0, 4'd9, 2'd0, 4'd15, 1'b0, 0, 0, 3, 1'b0};
    vecs[4] = '{4'd8, 2'd0, 4'd10, 2'd0, 4'd8, 1'b0, 0, 0, 4, 1'b1};
    vecs[5] = '{4'd3, 2'd2, 4'd5, 2'd1, 4'd15, 1'b0, 3, 0, 2, 1'b0};
    vecs[6] = '{4'd6, 2'd0, 4'd6, 2'd2, 4'd15, 1'b1, 4, 0, 0, 1'b1};

    rst_1plus = 1'b1; start = 1'b0; game_idle = 1'b1;
    target_x = 4'd0; target_dir = 2'd0;
    mx = 4'd0; mdir = 2'd0; m_wall = 4'd15; m_frz = 1'b0;
    pend_k = 5'd0; pend_cnt = 0; prev_k = 5'd0; idle_lost = 1'b0;
    tick(); tick();
    chk("reset_key", 32'(key_press_1plus), 32'd0);
    chk("reset_status", {29'd0, busy, done, blocked}, 32'd0);
    rst_1plus = 1'b0;

    // Latency with brick already on target: SPACE at edge 3, done at edge 4.
    load(4'd6, 2'd0, 4'd15, 1'b0);
    push_exp(0, 0, 0);
    start_seq(4'd6, 2'd0);
    chk("lat_busy_e0", {31'd0, busy}, 32'd1);
    chk("lat_key_e0", 32'(key_press_1plus), 32'd0);
    tick(); chk("lat_key_e1", 32'(key_press_1plus), 32'd0);
    tick(); chk("lat_key_e2", 32'(key_press_1plus), 32'd0);
    tick(); chk("lat_space_e3", 32'(key_press_1plus), 32'(K_SPACE));
    chk("lat_done_e3", {31'd0, done}, 32'd0);
    tick(); chk("lat_done_e4", {30'd0, done, busy}, 32'd2);
    tick(); chk("lat_done_e5", {31'd0, done}, 32'd0);
    chk("lat_blocked", {31'd0, blocked}, 32'd0);

    // Table of full sequences.
    for (int v = 0; v < 7; v++) begin
      load(vecs[v].x0, vecs[v].d0, vecs[v].wall, vecs[v].frz);
      push_exp(vecs[v].nup, vecs[v].nl, vecs[v].nr);
      start_seq(vecs[v].tx, vecs[v].td);
      wait_done($sformatf("vec%0d_done", v));
      tick();
      chk($sformatf("vec%0d_blocked", v), {31'd0, blocked}, {31'd0, vecs[v].blk});
      chk($sformatf("vec%0d_drained", v), 32'(exp_q.size()), 32'd0);
      if (!vecs[v].blk)
        chk($sformatf("vec%0d_final", v), {26'd0, mdir, mx}, {26'd0, vecs[v].td, vecs[v].tx});
    end

    // game_idle dropped mid-SHIFT: no pulses while low, resume right after.
    load(4'd6, 2'd0, 4'd15, 1'b0);
    push_exp(0, 4, 0);
    start_seq(4'd2, 2'd0);
    wait_pulse(K_LEFT, "hold_first_left");
    game_idle = 1'b0;
    np = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (key_press_1plus != 5'd0) np++;
    end
    chk("hold_no_pulse", 32'(np), 32'd0);
    game_idle = 1'b1;
    tick();
    chk("hold_resume", 32'(key_press_1plus), 32'(K_LEFT));
    wait_done("hold_done");
    chk("hold_final_x", 32'(mx), 32'd2);

    // Reset during a SHIFT gap aborts at once.
    load(4'd6, 2'd0, 4'd15, 1'b0);
    push_exp(0, 4, 0);
    start_seq(4'd2, 2'd0);
    wait_pulse(K_LEFT, "rst_first_left");
    tick();
    rst_1plus = 1'b1;
    #1;
    chk("rst_async_out", {24'd0, key_press_1plus, busy, done, blocked}, 32'd0);
    tick();
    chk("rst_out", {24'd0, key_press_1plus, busy, done, blocked}, 32'd0);
    chk("rst_state", 32'(dut.state), 32'(S_IDLE));
    rst_1plus = 1'b0;
    tick();

    // Fresh run after reset; a second start while busy and one in the DONE
    // cycle are both ignored.
    load(4'd6, 2'd0, 4'd15, 1'b0);
    push_exp(0, 4, 0);
    start_seq(4'd2, 2'd0);
    tick(); tick();
    target_x = 4'd9; target_dir = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_pulse(K_SPACE, "busy_space");
    target_x = 4'd9; target_dir = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_done", {30'd0, done, busy}, 32'd2);
    tick();
    chk("busy_late_start_ignored", {31'd0, busy}, 32'd0);
    chk("busy_orig_target", {26'd0, mdir, mx}, {26'd0, 2'd0, 4'd2});
    chk("busy_drained", 32'(exp_q.size()), 32'd0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
